// File: rtl/pipelined_addsub_pkg.sv
// Shared constants for the pipelined add/subtract unit and the ALU status bus.
package pipelined_addsub_pkg;

  localparam int ADDER_WIDTH  = 64;
  localparam int ADDER_STAGES = 4;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int NUM_FLAGS = 3;

  typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage : pipelined_addsub_pkg

// File: rtl/addsub_slice.sv
// Combinational W-bit carry-ripple adder slice; one instance per pipeline stage.
module addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W:0] carry;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[W];

endmodule : addsub_slice

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: STAGES registered ripple slices with a global
// advance enable, carry/overflow/zero flags and valid/ready back-pressure.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int W    = WIDTH / STAGES;
  localparam int MSB  = WIDTH - 1;
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

  logic                          adv;
  logic                          last_vin;
  logic [STAGES-1:0]             valid_q;

  // Operands, partial sum and carry as seen at the input of each slice.
  logic [STAGES-1:0][WIDTH-1:0]  op_a, op_b, op_s, s_nxt;
  logic [STAGES-1:0]             op_c;
  logic [STAGES-1:0][W-1:0]      slice_s;
  logic [STAGES-1:0]             slice_c;

  logic [NREG-1:0][WIDTH-1:0]    a_q, b_q, s_q;
  logic [NREG-1:0]               c_q;

  logic [WIDTH-1:0]              sum_d, sum_q;
  flags_t                        flags_d, flags_q;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv || rst;
  assign out_valid = valid_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_entry
      assign op_a[0] = a;
      assign op_b[0] = sub ? ~b : b;
      assign op_c[0] = sub ? 1'b1 : cin;
      assign op_s[0] = '0;
    end else begin : g_fwd
      assign op_a[k] = a_q[k-1];
      assign op_b[k] = b_q[k-1];
      assign op_c[k] = c_q[k-1];
      assign op_s[k] = s_q[k-1];
    end

    addsub_slice #(.W(W)) u_slice (
      .a_i    (op_a[k][k*W +: W]),
      .b_i    (op_b[k][k*W +: W]),
      .cin_i  (op_c[k]),
      .s_o    (slice_s[k]),
      .cout_o (slice_c[k])
    );

    // Bits above the current slice are still zero, so OR merges the new slice in.
    assign s_nxt[k] = op_s[k] | (WIDTH'(slice_s[k]) << (k * W));
  end

  if (STAGES == 1) begin : g_last_in
    assign last_vin = in_valid;
  end else begin : g_last_pipe
    assign last_vin = valid_q[STAGES-2];

    // NOTE: datapath registers are not reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
      if (adv) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          a_q[k] <= op_a[k];
          b_q[k] <= op_b[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= slice_c[k];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  always_comb begin
    sum_d           = s_nxt[STAGES-1];
    flags_d         = '0;
    flags_d[FLAG_C] = slice_c[STAGES-1];
    flags_d[FLAG_V] = (op_a[STAGES-1][MSB] == op_b[STAGES-1][MSB]) &&
                      (sum_d[MSB] != op_a[STAGES-1][MSB]);
    flags_d[FLAG_Z] = (sum_d == '0);
  end

  // Result and flags are captured together and held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      flags_q <= '0;
    end else if (adv && last_vin) begin
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign sum  = sum_q;
  assign cout = flags_q[FLAG_C];
  assign ovf  = flags_q[FLAG_V];
  assign zero = flags_q[FLAG_Z];

endmodule : pipelined_addsub

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: directed vectors, stall/flush scenarios and random traffic
// against an arithmetic reference model, plus WIDTH=32 variants at STAGES=1 and 32.
module tb_pipelined_addsub;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, sum;
  logic        cin, sub, cout, ovf, zero;

  logic        v_in_valid, v_cin, v_sub;
  logic [31:0] v_a, v_b;
  logic        v1_in_ready, v1_out_valid, v1_cout, v1_ovf, v1_zero;
  logic [31:0] v1_sum;
  logic        v32_in_ready, v32_out_valid, v32_cout, v32_ovf, v32_zero;
  logic [31:0] v32_sum;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  res_t sb_q[$];
  bit   hold_pending = 0;
  res_t hold_val;
  bit   sender_done;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v1_in_ready),
    .a(v_a), .b(v_b), .cin(v_cin), .sub(v_sub),
    .out_valid(v1_out_valid), .out_ready(1'b1),
    .sum(v1_sum), .cout(v1_cout), .ovf(v1_ovf), .zero(v1_zero)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(32)) dut_s32 (
    .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v32_in_ready),
    .a(v_a), .b(v_b), .cin(v_cin), .sub(v_sub),
    .out_valid(v32_out_valid), .out_ready(1'b1),
    .sum(v32_sum), .cout(v32_cout), .ovf(v32_ovf), .zero(v32_zero)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: unbounded arithmetic, then truncate; overflow means the exact
  // signed result does not fit in 64 bits.
  function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic mcin, input logic msub);
    logic [64:0] full;
    logic [65:0] exact;
    logic [65:0] ea, eb;
    res_t r;
    ea = {{2{ma[63]}}, ma};
    eb = {{2{mb[63]}}, mb};
    if (msub) begin
      full  = {1'b0, ma} + {1'b0, ~mb} + 65'd1;
      exact = ea - eb;
    end else begin
      full  = {1'b0, ma} + {1'b0, mb} + 65'(mcin);
      exact = ea + eb + 66'(mcin);
    end
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = !(exact[65:63] == 3'b000 || exact[65:63] == 3'b111);
    r.zero = (full[63:0] == 64'd0);
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'd0;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'(($urandom_range(0, 3)) << 16) - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {sum, cout, ovf, zero}, hold_val);
      end
      hold_pending = out_valid && !out_ready;
      hold_val     = {sum, cout, ovf, zero};
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) check("result", {sum, cout, ovf, zero}, sb_q.pop_front());
      end
      if (in_valid && in_ready) sb_q.push_back(model(a, b, cin, sub));
    end
  end

  // Call #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic send_beat(input logic [63:0] ta, input logic [63:0] tb_v,
                           input logic tcin, input logic tsub);
    bit acc = 0;
    int budget = 0;
    in_valid = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    if (!acc) check("send_timeout", acc, 1'b1);
  endtask

  task automatic run_vector(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                            input logic tcin, input logic tsub, input res_t exp);
    int lat = 1;
    send_beat(ta, tb_v, tcin, tsub);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, STAGES);
    check(tag, {sum, cout, ovf, zero}, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int out_base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v_in_valid = 1'b0; v_a = '0; v_b = '0; v_cin = 1'b0; v_sub = 1'b0;

    // Reset
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {sum, cout, ovf, zero}, 67'd0);
    check("idle_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Directed vectors
    run_vector("all_ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               {64'd0, 1'b1, 1'b0, 1'b1});
    run_vector("max_pos_plus1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0});
    run_vector("sub_5_7", 64'd5, 64'd7, 1'b1, 1'b1,
               {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});
    run_vector("sub_7_7", 64'd7, 64'd7, 1'b0, 1'b1,
               {64'd0, 1'b1, 1'b0, 1'b1});
    run_vector("sub_0_minneg", 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
               {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0});
    run_vector("carry_3_slices", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               {64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0});
    run_vector("cin_add", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0,
               {64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0});

    // 10 back-to-back beats with the consumer stalled in cycles 3-8
    out_base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(64'(i), 64'(i) << 32, 1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = !(c >= 3 && c <= 8);
          if (c == 6) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_sum_beat0", sum, 64'd0);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int g = 0; g < 50 && sb_q.size() != 0; g++) begin
      @(posedge clk); #1;
    end
    check("burst_drained", sb_q.size(), 0);
    check("burst_count", n_out - out_base, 10);

    // Flush a full pipe with a one-cycle reset
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(64'hDEAD_0000 + 64'(i), 64'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_full_valid", out_valid, 1'b1);
    check("flush_full_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_outputs", {sum, cout, ovf, zero}, 67'd0);
    out_ready = 1'b1;
    out_base = n_out;
    repeat (8) @(posedge clk);
    #1;
    check("flush_no_ghosts", n_out - out_base, 0);
    run_vector("after_flush", 64'd100, 64'd23, 1'b0, 1'b1, {64'd77, 1'b1, 1'b0, 1'b0});

    // Random traffic with random back-pressure
    sender_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_beat(pick(), pick(), 1'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        sender_done = 1;
      end
      begin
        for (int g = 0; g < 5000 && !(sender_done && sb_q.size() == 0); g++) begin
          out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    check("random_drained", sb_q.size(), 0);

    // WIDTH=32 variants, STAGES=1 and STAGES=32
    begin
      int lat1 = 0;
      int lat32 = 0;
      @(posedge clk); #1;
      v_in_valid = 1'b1; v_a = 32'hFFFF_FFFF; v_b = 32'd1; v_cin = 1'b1; v_sub = 1'b0;
      @(negedge clk);
      check("v1_in_ready", v1_in_ready, 1'b1);
      check("v32_in_ready", v32_in_ready, 1'b1);
      @(posedge clk); #1;
      v_in_valid = 1'b0; v_a = $urandom; v_b = $urandom;
      for (int c = 1; c <= 40; c++) begin
        if (v1_out_valid && lat1 == 0) begin
          lat1 = c;
          check("v1_result", {v1_sum, v1_cout, v1_ovf, v1_zero}, {32'd1, 1'b1, 1'b0, 1'b0});
        end
        if (v32_out_valid && lat32 == 0) begin
          lat32 = c;
          check("v32_result", {v32_sum, v32_cout, v32_ovf, v32_zero}, {32'd1, 1'b1, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
      end
      check("v1_latency", lat1, 1);
      check("v32_latency", lat32, 32);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipelined_addsub
